// File: rtl/usb_uart_tx_arbiter.sv
// Round-robin, message-granular sharer of the USB-serial byte port: 1-cycle arbitration, then owner bytes pass straight through.
// Bridge back-pressure stalls the owner indefinitely; with no host every offered byte is consumed and counted as dropped.
module usb_uart_tx_arbiter #(
  parameter int NUM_CLIENTS  = 3,
  parameter int MAX_BURST    = 64,
  parameter int IDLE_TIMEOUT = 255
) (
  input  logic                     clk_48mhz,
  input  logic                     reset,
  input  logic                     host_present,
  input  logic [NUM_CLIENTS-1:0]   cli_valid,
  input  logic [8*NUM_CLIENTS-1:0] cli_data,
  input  logic [NUM_CLIENTS-1:0]   cli_last,
  output logic [NUM_CLIENTS-1:0]   cli_ready,
  output logic                     uart_we,
  output logic [7:0]               uart_di,
  input  logic                     uart_wait,
  output logic [NUM_CLIENTS-1:0]   grant,
  output logic                     busy,
  output logic [15:0]              drop_count
);
  localparam int IW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  typedef enum logic {IDLE, GRANTED} state_t;

  state_t                 state_q, state_d;
  logic [NUM_CLIENTS-1:0] grant_q, grant_d;
  logic [IW-1:0]          owner_q, owner_d, last_owner_q, last_owner_d;
  logic [7:0]             beat_cnt_q, beat_cnt_d, stall_cnt_q, stall_cnt_d;
  logic [15:0]            drop_q, drop_d;

  logic [7:0]    data_arr [NUM_CLIENTS];
  logic          own_valid, own_last, accept, pick_found, rel;
  logic [7:0]    own_data;
  logic [IW-1:0] pick_idx;
  logic [3:0]    drop_pop;
  logic [16:0]   drop_sum;
  int            best;

  for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_split
    assign data_arr[g] = cli_data[8*g +: 8];
  end

  assign own_valid = cli_valid[owner_q];
  assign own_last  = cli_last[owner_q];
  assign own_data  = data_arr[owner_q];
  assign accept    = (state_q == GRANTED) && host_present && own_valid && !uart_wait;

  // Nearest requester after last_owner wins: distance 0 is last_owner+1.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    best       = NUM_CLIENTS;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (cli_valid[i] && ((i + NUM_CLIENTS - 1 - int'(last_owner_q)) % NUM_CLIENTS) < best) begin
        best       = (i + NUM_CLIENTS - 1 - int'(last_owner_q)) % NUM_CLIENTS;
        pick_found = 1'b1;
        pick_idx   = IW'(i);
      end
    end
  end

  always_comb begin
    drop_pop = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      drop_pop = drop_pop + {3'b000, cli_valid[i]};
    end
    drop_sum = {1'b0, drop_q} + {13'b0, drop_pop};
    drop_d   = drop_q;
    if (!host_present) begin
      drop_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      last_owner_q <= IW'(NUM_CLIENTS - 1);
      beat_cnt_q   <= '0;
      stall_cnt_q  <= '0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      drop_q       <= drop_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    rel          = 1'b0;
    case (state_q)
      IDLE: begin
        if (host_present && pick_found) begin
          state_d     = GRANTED;
          owner_d     = pick_idx;
          beat_cnt_d  = '0;
          stall_cnt_d = '0;
          for (int i = 0; i < NUM_CLIENTS; i++) begin
            grant_d[i] = (pick_idx == IW'(i));
          end
        end
      end
      GRANTED: begin
        if (!host_present) begin
          rel = 1'b1;
        end else if (accept) begin
          beat_cnt_d  = beat_cnt_q + 8'd1;
          stall_cnt_d = '0;
          rel         = own_last || (beat_cnt_q == 8'(MAX_BURST - 1));
        end else if (!own_valid) begin
          // A byte held off by uart_wait is not a stall; only an absent byte counts.
          stall_cnt_d = stall_cnt_q + 8'd1;
          rel         = (stall_cnt_q == 8'(IDLE_TIMEOUT - 1));
        end
      end
      default: state_d = IDLE;
    endcase
    if (rel) begin
      state_d      = IDLE;
      grant_d      = '0;
      last_owner_d = owner_q;
    end
  end

  always_comb begin
    cli_ready  = '0;
    uart_we    = 1'b0;
    uart_di    = 8'h00;
    busy       = 1'b0;
    grant      = '0;
    drop_count = drop_q;
    if (reset) begin
      cli_ready = '0;
    end else if (!host_present) begin
      cli_ready = cli_valid;
    end else if (state_q == GRANTED) begin
      uart_we            = own_valid;
      uart_di            = own_valid ? own_data : 8'h00;
      cli_ready[owner_q] = !uart_wait;
      busy               = 1'b1;
      grant              = grant_q;
    end
  end
endmodule

// File: tb/tb_usb_uart_tx_arbiter.sv
// Bench for usb_uart_tx_arbiter: directed vector table, hand-written corner sequences,
// and randomized traffic compared against a queue-based ownership model.
module tb_usb_uart_tx_arbiter;
  localparam int N    = 3;
  localparam int MAXB = 4;
  localparam int TMO  = 8;

  logic          clk = 1'b0;
  logic          rst, host, wait_i;
  logic [N-1:0]  valid, last, ready, grant;
  logic [8*N-1:0] data;
  logic          we, busy;
  logic [7:0]    di;
  logic [15:0]   drop;

  usb_uart_tx_arbiter #(.NUM_CLIENTS(N), .MAX_BURST(MAXB), .IDLE_TIMEOUT(TMO)) dut (
    .clk_48mhz(clk), .reset(rst), .host_present(host),
    .cli_valid(valid), .cli_data(data), .cli_last(last), .cli_ready(ready),
    .uart_we(we), .uart_di(di), .uart_wait(wait_i),
    .grant(grant), .busy(busy), .drop_count(drop)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
  endtask

  typedef struct {
    logic r; logic h; logic [2:0] v; logic [23:0] d; logic [2:0] l; logic w;
    logic [2:0] eg; logic ew; logic [7:0] edi; logic [2:0] er; logic eb;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic h, logic [2:0] v, logic [23:0] d, logic [2:0] l, logic w,
                              logic [2:0] eg, logic ew, logic [7:0] edi, logic [2:0] er, logic eb);
    vec_t t;
    t.r = r; t.h = h; t.v = v; t.d = d; t.l = l; t.w = w;
    t.eg = eg; t.ew = ew; t.edi = edi; t.er = er; t.eb = eb;
    return t;
  endfunction

  typedef struct { logic [7:0] d; logic l; } beat_t;
  beat_t      pq [N][$];
  logic [7:0] xlog[$];
  logic [N-1:0] last_acc;
  int offer_pct;

  // Reference: who owns the port, how many bytes it sent, how long it has been silent.
  int m_owner, m_last, m_beats, m_stalls, m_drops;

  task automatic drive_producers();
    for (int i = 0; i < N; i++) begin
      if (last_acc[i]) begin
        void'(pq[i].pop_front());
        valid[i] = 1'b0;
        last[i]  = 1'b0;
      end
      if (!valid[i] && pq[i].size() > 0 && $urandom_range(99) < offer_pct) begin
        valid[i]        = 1'b1;
        data[8*i +: 8]  = pq[i][0].d;
        last[i]         = pq[i][0].l;
      end
    end
    last_acc = '0;
  endtask

  task automatic step_model();
    logic [N-1:0] eg, er, acc;
    logic ew, eb;
    logic [7:0] edi;
    int k;
    @(negedge clk);
    eg = '0; er = '0; ew = 1'b0; eb = 1'b0; edi = 8'h00;
    if (!host) begin
      er = valid;
    end else if (m_owner >= 0) begin
      eg = 3'b001 << m_owner;
      ew = valid[m_owner];
      edi = ew ? data[8*m_owner +: 8] : 8'h00;
      er[m_owner] = !wait_i;
      eb = 1'b1;
    end
    chk("grant", grant, eg);
    chk("uart_we", we, ew);
    chk("uart_di", di, edi);
    chk("cli_ready", ready, er);
    chk("busy", busy, eb);
    chk("drop_count", drop, m_drops);
    if (we && !wait_i) xlog.push_back(di);
    acc = valid & er;
    if (!host) begin
      if (m_owner >= 0) begin m_last = m_owner; m_owner = -1; end
      m_drops = m_drops + $countones(acc);
      if (m_drops > 65535) m_drops = 65535;
    end else if (m_owner < 0) begin
      for (int j = 1; j <= N; j++) begin
        k = (m_last + j) % N;
        if (valid[k]) begin m_owner = k; m_beats = 0; m_stalls = 0; break; end
      end
    end else begin
      k = m_owner;
      if (acc[k]) begin
        m_beats++; m_stalls = 0;
        if (last[k] || m_beats == MAXB) begin m_last = k; m_owner = -1; end
      end else if (!valid[k]) begin
        m_stalls++;
        if (m_stalls == TMO) begin m_last = k; m_owner = -1; end
      end
    end
    last_acc = acc;
    @(posedge clk); #1;
    drive_producers();
  endtask

  task automatic reset_all();
    rst = 1'b1; host = 1'b1; valid = '0; data = '0; last = '0; wait_i = 1'b0;
    offer_pct = 100; last_acc = '0;
    for (int i = 0; i < N; i++) pq[i].delete();
    xlog.delete();
    m_owner = -1; m_last = N - 1; m_beats = 0; m_stalls = 0; m_drops = 0;
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_drop", drop, 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  function automatic beat_t bt(logic [7:0] d, logic l);
    beat_t b;
    b.d = d; b.l = l;
    return b;
  endfunction

  logic [7:0] exp3 [11] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h77, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19};

  initial begin
    // r h  valid  data        last   w | grant we di     ready  busy
    tbl.push_back(mk(1, 1, 3'b000, 24'h000000, 3'b000, 0, 3'b000, 0, 8'h00, 3'b000, 0));
    tbl.push_back(mk(0, 1, 3'b001, 24'h000048, 3'b000, 0, 3'b000, 0, 8'h00, 3'b000, 0));
    tbl.push_back(mk(0, 1, 3'b001, 24'h000048, 3'b000, 0, 3'b001, 1, 8'h48, 3'b001, 1));
    tbl.push_back(mk(0, 1, 3'b001, 24'h000049, 3'b001, 0, 3'b001, 1, 8'h49, 3'b001, 1));
    tbl.push_back(mk(0, 1, 3'b000, 24'h000000, 3'b000, 0, 3'b000, 0, 8'h00, 3'b000, 0));
    tbl.push_back(mk(1, 1, 3'b000, 24'h000000, 3'b000, 0, 3'b000, 0, 8'h00, 3'b000, 0));
    for (int rr = 0; rr < 6; rr++) begin
      tbl.push_back(mk(0, 1, 3'b111, 24'hA2A1A0, 3'b111, 0, 3'b000, 0, 8'h00, 3'b000, 0));
      tbl.push_back(mk(0, 1, 3'b111, 24'hA2A1A0, 3'b111, 0, 3'(1 << (rr % 3)), 1,
                       8'(8'hA0 + rr % 3), 3'(1 << (rr % 3)), 1));
    end

    rst = 1'b1; host = 1'b1; valid = '0; data = '0; last = '0; wait_i = 1'b0;
    @(posedge clk); #1;
    foreach (tbl[n]) begin
      rst = tbl[n].r; host = tbl[n].h; valid = tbl[n].v; data = tbl[n].d;
      last = tbl[n].l; wait_i = tbl[n].w;
      @(negedge clk);
      chk($sformatf("tbl%0d_grant", n), grant, tbl[n].eg);
      chk($sformatf("tbl%0d_we", n), we, tbl[n].ew);
      chk($sformatf("tbl%0d_di", n), di, tbl[n].edi);
      chk($sformatf("tbl%0d_ready", n), ready, tbl[n].er);
      chk($sformatf("tbl%0d_busy", n), busy, tbl[n].eb);
      if (tbl[n].r) chk($sformatf("tbl%0d_drop", n), drop, 0);
      @(posedge clk); #1;
    end

    // Burst limit: client 1 streams 10 bytes without last, client 2 waits with one message.
    reset_all();
    for (int b = 0; b < 10; b++) pq[1].push_back(bt(8'(8'h10 + b), 1'b0));
    pq[2].push_back(bt(8'h77, 1'b1));
    drive_producers();
    repeat (40) step_model();
    chk("burst_count", xlog.size(), 11);
    for (int e = 0; e < 11; e++)
      chk($sformatf("burst_byte%0d", e), (e < xlog.size()) ? 32'(xlog[e]) : 32'hDEAD, exp3[e]);

    // Long bridge back-pressure mid-message.
    reset_all();
    pq[0].push_back(bt(8'h31, 1'b0));
    pq[0].push_back(bt(8'h32, 1'b0));
    pq[0].push_back(bt(8'h33, 1'b1));
    drive_producers();
    step_model();
    step_model();
    wait_i = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      chk("wait_hold_grant", grant, 3'b001);
      step_model();
    end
    chk("wait_no_xfer", xlog.size(), 1);
    wait_i = 1'b0;
    step_model();
    chk("wait_release_count", xlog.size(), 2);
    chk("wait_release_byte", (xlog.size() == 2) ? 32'(xlog[1]) : 32'hDEAD, 8'h32);
    step_model();
    step_model();
    chk("wait_done_grant", grant, 3'b000);
    chk("wait_done_count", xlog.size(), 3);

    // Idle timeout: client 1 goes silent, client 0 waiting.
    reset_all();
    pq[1].push_back(bt(8'h55, 1'b0));
    drive_producers();
    step_model();
    pq[0].push_back(bt(8'h66, 1'b1));
    drive_producers();
    step_model();
    for (int s = 1; s <= TMO; s++) begin
      chk($sformatf("tmo_hold%0d", s), grant, 3'b010);
      step_model();
    end
    chk("tmo_release", grant, 3'b000);
    step_model();
    chk("tmo_next", grant, 3'b001);
    step_model();
    chk("tmo_next_byte", (xlog.size() == 2) ? 32'(xlog[1]) : 32'hDEAD, 8'h66);

    // No host: bytes from clients 0 and 2 are swallowed and counted.
    reset_all();
    host = 1'b0;
    for (int b = 0; b < 3; b++) begin
      pq[0].push_back(bt(8'(8'hC0 + b), 1'b0));
      pq[2].push_back(bt(8'(8'hE0 + b), b == 2));
    end
    drive_producers();
    repeat (3) step_model();
    chk("drop_six", drop, 16'd6);
    chk("drop_drained", pq[0].size() + pq[2].size(), 0);
    chk("drop_no_xfer", xlog.size(), 0);
    for (int i = 0; i < N; i++) begin
      pq[i].push_back(bt(8'h01, 1'b0));
      pq[i].push_back(bt(8'h02, 1'b0));
    end
    drive_producers();
    for (int c = 0; c < 21850; c++) begin
      for (int i = 0; i < N; i++) pq[i].push_back(bt(8'(c), 1'b0));
      step_model();
    end
    chk("drop_saturate", drop, 16'hFFFF);

    // Async reset in the middle of a granted message.
    for (int i = 0; i < N; i++) pq[i].delete();
    valid = '0; last = '0; last_acc = '0;
    host = 1'b1;
    pq[0].push_back(bt(8'hA1, 1'b0));
    pq[0].push_back(bt(8'hA2, 1'b0));
    pq[0].push_back(bt(8'hA3, 1'b1));
    drive_producers();
    step_model();
    step_model();
    chk("pre_rst_grant", grant, 3'b001);
    rst = 1'b1;
    #1;
    chk("async_rst_grant", grant, 3'b000);
    chk("async_rst_drop", drop, 16'h0000);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_we", we, 1'b0);
    chk("async_rst_ready", ready, 3'b000);

    // Randomized traffic with back-pressure and occasional host loss.
    reset_all();
    offer_pct = 70;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if (pq[i].size() < 2) pq[i].push_back(bt(8'($urandom_range(255)), $urandom_range(99) < 30));
      wait_i = ($urandom_range(99) < 30);
      host   = ($urandom_range(99) >= 3);
      step_model();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
